// File: rtl/decode_unit_pkg.sv
// Shared types and constants for the ID stage: opcodes, immediate formats,
// branch funct3 codes, the ID/EX payload layout and the branch comparator.
package decode_unit_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int XLEN_DEF   = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

    typedef enum logic {CMP_IDLE, CMP_PEND} cmp_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [31:0]           inst;
        logic [XLEN_DEF-1:0]   imm;
        logic [XLEN_DEF-1:0]   rs1_data;
        logic [XLEN_DEF-1:0]   rs2_data;
        logic [4:0]            rd;
        logic                  rd_we;
        logic                  illegal;
    } id_ex_t;

    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic logic branch_cmp(input logic [XLEN_DEF-1:0] a,
                                        input logic [XLEN_DEF-1:0] b,
                                        input logic [2:0]          f3);
        logic res;
        res = 1'b0;
        case (f3)
            F3_BEQ:  res = (a == b);
            F3_BNE:  res = (a != b);
            F3_BLT:  res = ($signed(a) <  $signed(b));
            F3_BGE:  res = ($signed(a) >= $signed(b));
            F3_BLTU: res = (a <  b);
            F3_BGEU: res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Fetch-side, regfile, and EX-side signals of the decode stage.
// slave = decode unit's view; master = the surrounding pipeline's view.
interface decode_unit_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              valid_i;
    logic [31:0]       inst_i;
    logic [ADDR_W-1:0] pc_i;
    logic              ready_o;
    logic              jmp_o;
    logic              branch_o;
    logic [ADDR_W-1:0] jmp_target_o;
    logic              branch_cmp_result_valid_o;
    logic              branch_cmp_result_o;
    logic [4:0]        rs1_addr_o;
    logic [4:0]        rs2_addr_o;
    logic [XLEN-1:0]   rs1_data_i;
    logic [XLEN-1:0]   rs2_data_i;
    logic              hazard_i;
    logic              flush_i;
    logic              ex_ready_i;
    logic              ex_valid_o;
    logic [ADDR_W-1:0] ex_pc_o;
    logic [31:0]       ex_inst_o;
    logic [XLEN-1:0]   ex_imm_o;
    logic [XLEN-1:0]   ex_rs1_data_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [4:0]        ex_rd_o;
    logic              ex_rd_we_o;
    logic              ex_illegal_o;

    modport slave (
        input  valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i, hazard_i, flush_i, ex_ready_i,
        output ready_o, jmp_o, branch_o, jmp_target_o, branch_cmp_result_valid_o,
               branch_cmp_result_o, rs1_addr_o, rs2_addr_o, ex_valid_o, ex_pc_o, ex_inst_o,
               ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o, ex_illegal_o
    );

    modport master (
        output valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i, hazard_i, flush_i, ex_ready_i,
        input  ready_o, jmp_o, branch_o, jmp_target_o, branch_cmp_result_valid_o,
               branch_cmp_result_o, rs1_addr_o, rs2_addr_o, ex_valid_o, ex_pc_o, ex_inst_o,
               ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o, ex_illegal_o
    );
endinterface

// File: rtl/decode_unit_imm_gen.sv
// Combinational immediate extractor: picks the format from the opcode and
// returns the sign-extended immediate (0 when the opcode carries none).
module imm_gen_sbm
    import decode_unit_pkg::*;
(
    input  logic [31:0] inst,
    output imm_fmt_e    imm_fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm_fmt = IMM_NONE;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_fmt = IMM_I;
            OPC_STORE:                      imm_fmt = IMM_S;
            OPC_BRANCH:                     imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_fmt = IMM_U;
            OPC_JAL:                        imm_fmt = IMM_J;
            default:                        imm_fmt = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_fmt)
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {inst[31:12], 12'b0};
            IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_unit.sv
// ID stage: decodes one instruction per handshake, resolves jump/branch
// targets for fetch, and registers the ID/EX payload.
//
// state    | meaning
// CMP_IDLE | no branch outcome outstanding
// CMP_PEND | branch accepted last cycle; resolution pulse this cycle, intake blocked
module decode_unit
    import decode_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int XLEN   = XLEN_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    decode_unit_if.slave  io
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    imm_fmt_e    imm_fmt;
    logic [31:0] imm;

    logic is_jal, is_jalr, is_branch, opc_known, writes_rd, illegal;
    logic branch_ok, accept, br_accept, ready;
    logic [ADDR_W-1:0] jalr_sum, target;

    cmp_state_e state_q, state_d;
    logic       cmp_result_q;
    logic       ex_valid_q;
    id_ex_t     ex_q, dec;

    assign opcode = io.inst_i[6:0];
    assign funct3 = io.inst_i[14:12];
    assign rd     = io.inst_i[11:7];

    imm_gen_sbm u_imm_gen (
        .inst    (io.inst_i),
        .imm_fmt (imm_fmt),
        .imm     (imm)
    );

    always_comb begin
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        opc_known = 1'b1;
        writes_rd = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC: writes_rd = 1'b1;
            OPC_JAL:    begin is_jal  = 1'b1; writes_rd = 1'b1; end
            OPC_JALR:   begin is_jalr = 1'b1; writes_rd = 1'b1; end
            OPC_BRANCH: is_branch = 1'b1;
            OPC_STORE:  opc_known = 1'b1;
            default:    opc_known = 1'b0;
        endcase
    end

    assign branch_ok = is_branch & branch_f3_ok(funct3);
    assign illegal   = !opc_known | (is_branch & !branch_f3_ok(funct3));

    assign ready     = (state_q != CMP_PEND) & !io.hazard_i & !io.flush_i
                     & (!ex_valid_q | io.ex_ready_i);
    assign accept    = io.valid_i & ready;
    assign br_accept = accept & branch_ok;

    // JALR target drops bit 0 after the add; JAL/branch share pc + imm.
    assign jalr_sum = io.rs1_data_i[ADDR_W-1:0] + imm[ADDR_W-1:0];
    assign target   = is_jalr ? (jalr_sum & ~ADDR_W'(1)) : (io.pc_i + imm[ADDR_W-1:0]);

    always_comb begin
        dec          = '0;
        dec.pc       = io.pc_i;
        dec.inst     = io.inst_i;
        dec.imm      = imm;
        dec.rs1_data = io.rs1_data_i;
        dec.rs2_data = io.rs2_data_i;
        dec.rd       = rd;
        dec.rd_we    = writes_rd & !illegal & (rd != 5'd0);
        dec.illegal  = illegal;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CMP_IDLE: if (br_accept) state_d = CMP_PEND;
            CMP_PEND: state_d = CMP_IDLE;
            default:  state_d = CMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CMP_IDLE;
            cmp_result_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (br_accept)
                cmp_result_q <= branch_cmp(io.rs1_data_i, io.rs2_data_i, funct3);
        end
    end

    // flush only kills the valid bit; ready is already low so no load can collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (io.flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_q       <= dec;
        end else if (io.ex_ready_i) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign io.ready_o                   = ready;
    assign io.jmp_o                     = accept & (is_jal | is_jalr);
    assign io.branch_o                  = br_accept;
    assign io.jmp_target_o              = target;
    assign io.branch_cmp_result_valid_o = (state_q == CMP_PEND);
    assign io.branch_cmp_result_o       = cmp_result_q;
    assign io.rs1_addr_o                = io.inst_i[19:15];
    assign io.rs2_addr_o                = io.inst_i[24:20];

    assign io.ex_valid_o    = ex_valid_q;
    assign io.ex_pc_o       = ex_q.pc;
    assign io.ex_inst_o     = ex_q.inst;
    assign io.ex_imm_o      = ex_q.imm;
    assign io.ex_rs1_data_o = ex_q.rs1_data;
    assign io.ex_rs2_data_o = ex_q.rs2_data;
    assign io.ex_rd_o       = ex_q.rd;
    assign io.ex_rd_we_o    = ex_q.rd_we;
    assign io.ex_illegal_o  = ex_q.illegal;

endmodule

// File: doc/decode_unit.md
Name: decode_unit

Overview:
- ID stage of the in-order core, directly downstream of the fetch unit.
- Accepts one instruction and PC per valid/ready handshake and decodes it.
- Reads the external register file; resolves JAL/JALR targets and branch targets and comparisons back to fetch.
- Drives a registered ID/EX payload with its own valid/ready handshake toward EX.

Parameters:
- ADDR_W, 32, PC/target width.
- XLEN, 32, register data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- valid_i  in  1  inst_i/pc_i valid from fetch
- inst_i  in  32  instruction
- pc_i  in  ADDR_W  instruction PC
- ready_o  out  1  decode accepts inst this cycle
- jmp_o  out  1  JAL/JALR accepted this cycle
- branch_o  out  1  conditional branch accepted this cycle
- jmp_target_o  out  ADDR_W  jump/branch target
- branch_cmp_result_valid_o  out  1  branch resolution pulse
- branch_cmp_result_o  out  1  1 = branch taken
- rs1_addr_o  out  5  regfile read address 1 (inst_i[19:15])
- rs2_addr_o  out  5  regfile read address 2 (inst_i[24:20])
- rs1_data_i  in  XLEN  regfile read data 1, same cycle
- rs2_data_i  in  XLEN  regfile read data 2, same cycle
- hazard_i  in  1  scoreboard: a source register of inst_i is pending
- flush_i  in  1  EX-side kill of the ID/EX payload
- ex_ready_i  in  1  EX accepts payload
- ex_valid_o  out  1  payload valid
- ex_pc_o  out  ADDR_W  payload PC
- ex_inst_o  out  32  payload raw instruction
- ex_imm_o  out  XLEN  sign-extended immediate
- ex_rs1_data_o  out  XLEN  operand 1
- ex_rs2_data_o  out  XLEN  operand 2
- ex_rd_o  out  5  destination register
- ex_rd_we_o  out  1  writeback enable
- ex_illegal_o  out  1  unrecognised opcode/funct3

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. On reset all ex_* outputs are 0, cmp_pending_q=0, and branch_cmp_result_o=0.
- ready_o = !cmp_pending_q & !hazard_i & !flush_i & (!ex_valid_o | ex_ready_i). Define accept = valid_i & ready_o.
- Payload register:
  - On accept, load all ex_* fields from the current decode and set ex_valid_o=1.
  - Otherwise, if ex_ready_i, clear ex_valid_o.
  - Otherwise hold all fields stable.
  - flush_i has highest priority: next cycle ex_valid_o=0, and no accept occurs that cycle.
- Immediate by format:
  - I: OP_IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - All sign-extended to XLEN; B and J have imm[0]=0. Any other opcode gives imm 0 and ex_illegal_o=1.
- Writeback enable:
  - ex_rd_we_o=1 for OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR when rd!=0.
  - ex_rd_we_o=0 otherwise, and 0 for illegal instructions.
- Target computation (ADDR_W arithmetic, wrap-around mod 2^ADDR_W, combinational on inst_i/pc_i):
  - JAL: pc_i+immJ.
  - JALR: (rs1_data_i+immI) & ~1.
  - BRANCH: pc_i+immB.
- jmp_o = accept & (JAL|JALR).
- branch_o = accept & BRANCH & valid funct3. Valid funct3 values: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. funct3 010/011 counts as illegal, with branch_o=0.
- Each control-flow instruction asserts jmp_o/branch_o for exactly one cycle.
- Branch resolution:
  - On a branch accept, register cmp_result_q = compare(rs1_data_i, rs2_data_i, funct3) (signed for BLT/BGE, unsigned for BLTU/BGEU) and set cmp_pending_q=1.
  - Next cycle branch_cmp_result_valid_o=1 and branch_cmp_result_o=cmp_result_q, then cmp_pending_q clears.
  - Latency is exactly 1 cycle from branch_o to resolution.
  - ready_o=0 during the pending cycle, which forces a one-bubble gap after every branch.
  - flush_i does not cancel a pending resolution pulse.
- Branch and JAL/JALR are also forwarded to EX as ordinary payload (branch ex_rd_we_o=0).
- hazard_i=1 with valid_i: stall, no payload load, no jmp_o/branch_o. The instruction is re-evaluated every cycle until hazard_i drops.
- EX back-pressure (ex_valid_o & !ex_ready_i): the payload holds and ready_o=0.
- Reset mid-operation: a pending pulse or held payload is discarded immediately.

Decomposition:
- The typedefs package already holds OPC_*. Add to it:
  - imm_fmt_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
  - Branch funct3 constants (F3_BEQ…F3_BGEU).
  - id_ex_t packed struct for the payload.
- Sub-module imm_gen_sbm is purely combinational: inst[31:0] -> imm_fmt, imm. It is shared with later units.

Test Plan:
- ADDI x5,x0,7 (0x00700293), pc 0x100, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_imm_o=7, ex_rd_o=5, ex_rd_we_o=1, ex_pc_o=0x100.
- BEQ x1,x2,+16 at pc 0x200, rs1=rs2=3 -> same cycle branch_o=1 and jmp_target_o=0x210; next cycle branch_cmp_result_valid_o=1, result=1, ready_o=0; following cycle ready_o=1.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> result=1. Same operands with BLTU -> result=0.
- JALR x1,8(x3), rs1=0x1003 -> jmp_o=1 one cycle, jmp_target_o=0x100A (bit0 cleared), ex_rd_we_o=1.
- ex_ready_i=0 for 3 cycles with payload held, valid_i=1 -> ready_o=0, ex_* stable, no jmp_o/branch_o. On ex_ready_i=1 the next instruction loads.
- flush_i during a pending branch -> ex_valid_o=0 next cycle and the resolution pulse still fires. An opcode 0x7F instruction -> ex_illegal_o=1, ex_rd_we_o=0.
